pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 8'd255, giving the MEM-stage wait cycles before forced release.
REQ-002 SHALL have port clk, input, 1, the single clock, with all state updated on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have ports id_rs1_addr_i and id_rs2_addr_i, input, 5 each, the source register addresses in ID.
REQ-005 SHALL have ports id_rs1_read_i and id_rs2_read_i, input, 1 each, the source-used flags in ID.
REQ-006 SHALL have ports ex_rd_addr_i (input, 5), ex_wreg_i (input, 1) and ex_is_load_i (input, 1), describing the instruction in EX.
REQ-007 SHALL have port ex_branch_taken_i, input, 1, the EX redirect request.
REQ-008 SHALL have ports if_req_i and if_ack_i, input, 1 each, the fetch handshake.
REQ-009 SHALL have ports mem_req_i and mem_ack_i, input, 1 each, the data-bus handshake for MEM.
REQ-010 SHALL have ports pc_ctrl_o, if_id_ctrl_o, id_ex_ctrl_o, ex_mem_ctrl_o and mem_wb_ctrl_o, output, CTRL_Wire_Bus (2) each, the per-register control.
REQ-011 SHALL have port bus_err_o, output, 1, a one-cycle timeout pulse.
REQ-012 SHALL have ports stall_cnt_o and flush_cnt_o, output, 32 each, the performance counters.

Function
REQ-013 SHALL encode control as CTRL_STATE_Normal=2'b00 (load), CTRL_STATE_Block=2'b01 (hold), CTRL_STATE_Flush=2'b10 (load bubble).
REQ-014 SHALL implement FSM states RUN and MEM_WAIT; RUN->MEM_WAIT when mem_req_i & !mem_ack_i; MEM_WAIT->RUN on mem_ack_i or timeout.
REQ-015 SHALL define mem_stall = mem_req_i & !mem_ack_i & !timeout_hit, where timeout_hit = (state==MEM_WAIT) & (wait_cnt==MEM_TIMEOUT-1).
REQ-016 SHALL clear wait_cnt (8 bit) in RUN and increment it each MEM_WAIT cycle without ack; it SHALL never wrap.
REQ-017 SHALL pulse bus_err_o exactly in the cycle timeout_hit is true; that cycle is treated as ack.
REQ-018 SHALL define load_use = ex_is_load_i & ex_wreg_i & (ex_rd_addr_i!=0) & ((id_rs1_read_i & rs1==rd) | (id_rs2_read_i & rs2==rd)).
REQ-019 SHALL define fetch_stall = if_req_i & !if_ack_i.
REQ-020 SHALL generate outputs combinationally from the highest-priority active condition, in the order mem_stall > branch > load_use > fetch_stall > none.
REQ-021 SHALL drive, on mem_stall: pc, IF_ID, ID_EX and EX_MEM=Block, and MEM_WB=Flush.
REQ-022 SHALL drive, on branch: pc=Normal, IF_ID=Flush, ID_EX=Flush, and EX_MEM and MEM_WB=Normal.
REQ-023 SHALL drive, on load_use: pc=Block, IF_ID=Block, ID_EX=Flush, and EX_MEM and MEM_WB=Normal.
REQ-024 SHALL drive, on fetch_stall only: pc=Block, IF_ID=Flush, and all others Normal.
REQ-025 SHALL drive all outputs Normal when no condition is active.
REQ-026 SHALL make branch coincident with load_use or fetch_stall resolve as branch, and any of them coincident with mem_stall resolve as mem_stall.
REQ-027 SHALL increment stall_cnt_o in every cycle in which pc_ctrl_o==Block, and increment flush_cnt_o in every cycle in which branch wins priority; both SHALL saturate at 32'hFFFFFFFF.

Reset
REQ-028 SHALL, while rst==0, set state=RUN, wait_cnt=0, stall_cnt_o=0, flush_cnt_o=0 and bus_err_o=0, and drive all ctrl outputs Flush.
REQ-029 SHALL, on rst assertion mid-MEM_WAIT, abandon the wait immediately without emitting bus_err_o; on release, operation SHALL resume in RUN.

Structure
REQ-030 SHALL take CTRL_Wire_Bus, the CTRL_STATE_* encodings, the RUN/MEM_WAIT state codes and the MEM_TIMEOUT default from defines.v.
REQ-031 SHALL use one sub-module, hazard_detect (combinational load_use), and keep the FSM and counters inline.

Verification
REQ-032 SHALL cover: EX load rd=5 with ID rs1=5 read -> one cycle of pc/IF_ID=Block, ID_EX=Flush, stall_cnt +1.
REQ-033 SHALL cover: EX load rd=0 matching rs1=0 -> all outputs Normal.
REQ-034 SHALL cover: mem_req=1 with ack delayed 3 cycles -> 3 cycles of Block/MEM_WB=Flush, Normal on the ack cycle, state back to RUN.
REQ-035 SHALL cover: MEM_TIMEOUT=4 with ack never given -> bus_err_o high in the 4th stall cycle only, ctrl Normal that cycle.
REQ-036 SHALL cover: branch_taken together with load_use and fetch_stall -> IF_ID/ID_EX=Flush, pc=Normal, flush_cnt +1; branch together with mem_stall -> mem_stall pattern.
REQ-037 SHALL cover: rst pulsed low during MEM_WAIT -> all ctrl outputs Flush, counters 0, no bus_err_o, RUN after release.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipeline controller: per-register control
// codes, FSM state codes and small helper functions.
package pipe_ctrl_pkg;

   typedef logic [1:0] CTRL_Wire_Bus;

   localparam CTRL_Wire_Bus CTRL_STATE_Normal = 2'b00;
   localparam CTRL_Wire_Bus CTRL_STATE_Block  = 2'b01;
   localparam CTRL_Wire_Bus CTRL_STATE_Flush  = 2'b10;

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } pipe_state_e;

   localparam logic [7:0] MEM_TIMEOUT_DEFAULT = 8'd255;

   typedef struct packed {
      CTRL_Wire_Bus pc;
      CTRL_Wire_Bus if_id;
      CTRL_Wire_Bus id_ex;
      CTRL_Wire_Bus ex_mem;
      CTRL_Wire_Bus mem_wb;
   } ctrl_bundle_t;

   function automatic ctrl_bundle_t mk_ctrl(input CTRL_Wire_Bus pc,
                                            input CTRL_Wire_Bus if_id,
                                            input CTRL_Wire_Bus id_ex,
                                            input CTRL_Wire_Bus ex_mem,
                                            input CTRL_Wire_Bus mem_wb);
      mk_ctrl = '{pc: pc, if_id: if_id, id_ex: id_ex, ex_mem: ex_mem, mem_wb: mem_wb};
   endfunction

   // Saturating increment: performance counters stick at all-ones.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      sat_inc32 = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detection: an EX load writing a register that ID is about
// to read must hold ID for one cycle. Register 0 never creates a hazard.
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] id_rs1_addr_i,
   input  logic [4:0] id_rs2_addr_i,
   input  logic       id_rs1_read_i,
   input  logic       id_rs2_read_i,
   input  logic [4:0] ex_rd_addr_i,
   input  logic       ex_wreg_i,
   input  logic       ex_is_load_i,
   output logic       load_use_o
);

   logic rs1_hit_s;
   logic rs2_hit_s;

   // Compare both ID sources against the EX destination.
   always_comb begin
      rs1_hit_s  = id_rs1_read_i & (id_rs1_addr_i == ex_rd_addr_i);
      rs2_hit_s  = id_rs2_read_i & (id_rs2_addr_i == ex_rd_addr_i);
      load_use_o = ex_is_load_i & ex_wreg_i & (ex_rd_addr_i != 5'd0) & (rs1_hit_s | rs2_hit_s);
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: prioritises memory stall, branch redirect,
// load-use and fetch stall into per-register load/hold/bubble controls.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter logic [7:0] MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [4:0]   id_rs1_addr_i,
   input  logic [4:0]   id_rs2_addr_i,
   input  logic         id_rs1_read_i,
   input  logic         id_rs2_read_i,
   input  logic [4:0]   ex_rd_addr_i,
   input  logic         ex_wreg_i,
   input  logic         ex_is_load_i,
   input  logic         ex_branch_taken_i,
   input  logic         if_req_i,
   input  logic         if_ack_i,
   input  logic         mem_req_i,
   input  logic         mem_ack_i,
   output CTRL_Wire_Bus pc_ctrl_o,
   output CTRL_Wire_Bus if_id_ctrl_o,
   output CTRL_Wire_Bus id_ex_ctrl_o,
   output CTRL_Wire_Bus ex_mem_ctrl_o,
   output CTRL_Wire_Bus mem_wb_ctrl_o,
   output logic         bus_err_o,
   output logic [31:0]  stall_cnt_o,
   output logic [31:0]  flush_cnt_o
);

   localparam logic [7:0] TIMEOUT_LAST = MEM_TIMEOUT - 8'd1;

   pipe_state_e  state_q, state_d;
   logic [7:0]   wait_cnt_q, wait_cnt_d;
   logic [31:0]  stall_cnt_q, stall_cnt_d;
   logic [31:0]  flush_cnt_q, flush_cnt_d;

   logic         load_use_s;
   logic         timeout_hit_s;
   logic         mem_stall_s;
   logic         fetch_stall_s;
   logic         branch_win_s;
   ctrl_bundle_t ctrl_s;
   ctrl_bundle_t ctrl_out_s;

   hazard_detect u_hazard_detect (
      .id_rs1_addr_i (id_rs1_addr_i),
      .id_rs2_addr_i (id_rs2_addr_i),
      .id_rs1_read_i (id_rs1_read_i),
      .id_rs2_read_i (id_rs2_read_i),
      .ex_rd_addr_i  (ex_rd_addr_i),
      .ex_wreg_i     (ex_wreg_i),
      .ex_is_load_i  (ex_is_load_i),
      .load_use_o    (load_use_s)
   );

   // The timeout cycle counts as an ack, so it releases the stall.
   always_comb begin
      timeout_hit_s = (state_q == MEM_WAIT) && (wait_cnt_q == TIMEOUT_LAST);
      mem_stall_s   = mem_req_i & ~mem_ack_i & ~timeout_hit_s;
      fetch_stall_s = if_req_i & ~if_ack_i;
   end

   // Priority resolution of the pipeline control pattern.
   always_comb begin
      branch_win_s = 1'b0;
      ctrl_s = mk_ctrl(CTRL_STATE_Normal, CTRL_STATE_Normal, CTRL_STATE_Normal,
                       CTRL_STATE_Normal, CTRL_STATE_Normal);
      if (mem_stall_s) begin
         ctrl_s = mk_ctrl(CTRL_STATE_Block, CTRL_STATE_Block, CTRL_STATE_Block,
                          CTRL_STATE_Block, CTRL_STATE_Flush);
      end else if (ex_branch_taken_i) begin
         branch_win_s = 1'b1;
         ctrl_s = mk_ctrl(CTRL_STATE_Normal, CTRL_STATE_Flush, CTRL_STATE_Flush,
                          CTRL_STATE_Normal, CTRL_STATE_Normal);
      end else if (load_use_s) begin
         ctrl_s = mk_ctrl(CTRL_STATE_Block, CTRL_STATE_Block, CTRL_STATE_Flush,
                          CTRL_STATE_Normal, CTRL_STATE_Normal);
      end else if (fetch_stall_s) begin
         ctrl_s = mk_ctrl(CTRL_STATE_Block, CTRL_STATE_Flush, CTRL_STATE_Normal,
                          CTRL_STATE_Normal, CTRL_STATE_Normal);
      end else begin
         ctrl_s = mk_ctrl(CTRL_STATE_Normal, CTRL_STATE_Normal, CTRL_STATE_Normal,
                          CTRL_STATE_Normal, CTRL_STATE_Normal);
      end
   end

   // Reset forces bubbles into every pipeline register.
   always_comb begin
      ctrl_out_s = ctrl_s;
      if (!rst) begin
         ctrl_out_s = mk_ctrl(CTRL_STATE_Flush, CTRL_STATE_Flush, CTRL_STATE_Flush,
                              CTRL_STATE_Flush, CTRL_STATE_Flush);
      end else begin
         ctrl_out_s = ctrl_s;
      end
   end

   assign pc_ctrl_o     = ctrl_out_s.pc;
   assign if_id_ctrl_o  = ctrl_out_s.if_id;
   assign id_ex_ctrl_o  = ctrl_out_s.id_ex;
   assign ex_mem_ctrl_o = ctrl_out_s.ex_mem;
   assign mem_wb_ctrl_o = ctrl_out_s.mem_wb;
   assign bus_err_o     = rst & timeout_hit_s;
   assign stall_cnt_o   = stall_cnt_q;
   assign flush_cnt_o   = flush_cnt_q;

   // Next-state for the MEM wait FSM, its wait counter and the perf counters.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         RUN: begin
            wait_cnt_d = 8'd0;
            if (mem_req_i && !mem_ack_i) begin
               state_d = MEM_WAIT;
            end else begin
               state_d = RUN;
            end
         end
         MEM_WAIT: begin
            if (mem_ack_i || timeout_hit_s) begin
               state_d    = RUN;
               wait_cnt_d = 8'd0;
            end else if (wait_cnt_q != 8'hFF) begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end else begin
               wait_cnt_d = wait_cnt_q;
            end
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = 8'd0;
         end
      endcase

      if (ctrl_out_s.pc == CTRL_STATE_Block) begin
         stall_cnt_d = sat_inc32(stall_cnt_q);
      end else begin
         stall_cnt_d = stall_cnt_q;
      end

      if (branch_win_s) begin
         flush_cnt_d = sat_inc32(flush_cnt_q);
      end else begin
         flush_cnt_d = flush_cnt_q;
      end
   end

   // State registers; reset abandons any outstanding MEM wait.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= RUN;
         wait_cnt_q  <= 8'd0;
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: each step queues the expected control pattern
// and counter values, which are popped and checked half a cycle later.
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   typedef enum int {P_NORM, P_MEM, P_BR, P_LU, P_FS, P_RST} pat_e;

   typedef struct {
      string       tag;
      logic [9:0]  ctrl;
      logic        berr;
      logic [31:0] st;
      logic [31:0] fl;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [4:0]   id_rs1_addr_i = 5'd0, id_rs2_addr_i = 5'd0, ex_rd_addr_i = 5'd0;
   logic         id_rs1_read_i = 1'b0, id_rs2_read_i = 1'b0;
   logic         ex_wreg_i = 1'b0, ex_is_load_i = 1'b0, ex_branch_taken_i = 1'b0;
   logic         if_req_i = 1'b0, if_ack_i = 1'b0, mem_req_i = 1'b0, mem_ack_i = 1'b0;
   CTRL_Wire_Bus pc_ctrl_o, if_id_ctrl_o, id_ex_ctrl_o, ex_mem_ctrl_o, mem_wb_ctrl_o;
   logic         bus_err_o;
   logic [31:0]  stall_cnt_o, flush_cnt_o;

   exp_t sb_q[$];
   int   n_total = 0;
   int   n_pass  = 0;
   int   m_stall = 0;
   int   m_flush = 0;

   pipe_ctrl #(.MEM_TIMEOUT(8'd4)) dut (
      .clk               (clk),
      .rst               (rst),
      .id_rs1_addr_i     (id_rs1_addr_i),
      .id_rs2_addr_i     (id_rs2_addr_i),
      .id_rs1_read_i     (id_rs1_read_i),
      .id_rs2_read_i     (id_rs2_read_i),
      .ex_rd_addr_i      (ex_rd_addr_i),
      .ex_wreg_i         (ex_wreg_i),
      .ex_is_load_i      (ex_is_load_i),
      .ex_branch_taken_i (ex_branch_taken_i),
      .if_req_i          (if_req_i),
      .if_ack_i          (if_ack_i),
      .mem_req_i         (mem_req_i),
      .mem_ack_i         (mem_ack_i),
      .pc_ctrl_o         (pc_ctrl_o),
      .if_id_ctrl_o      (if_id_ctrl_o),
      .id_ex_ctrl_o      (id_ex_ctrl_o),
      .ex_mem_ctrl_o     (ex_mem_ctrl_o),
      .mem_wb_ctrl_o     (mem_wb_ctrl_o),
      .bus_err_o         (bus_err_o),
      .stall_cnt_o       (stall_cnt_o),
      .flush_cnt_o       (flush_cnt_o)
   );

   always #5 clk = ~clk;

   // Expected {pc, if_id, id_ex, ex_mem, mem_wb}: N=00, B=01, F=10.
   function automatic logic [9:0] pat_ctrl(input pat_e p);
      case (p)
         P_MEM:   pat_ctrl = 10'b01_01_01_01_10;
         P_BR:    pat_ctrl = 10'b00_10_10_00_00;
         P_LU:    pat_ctrl = 10'b01_01_10_00_00;
         P_FS:    pat_ctrl = 10'b01_10_00_00_00;
         P_RST:   pat_ctrl = 10'b10_10_10_10_10;
         default: pat_ctrl = 10'b00_00_00_00_00;
      endcase
   endfunction

   task automatic chk(input string tag, input string what, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
   endtask

   task automatic step(input string tag, input logic r,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic rd1, input logic rd2,
                       input logic [4:0] exrd, input logic wr, input logic ld,
                       input logic br, input logic ifq, input logic ifa,
                       input logic mq, input logic ma,
                       input pat_e pat, input logic berr);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r;
      id_rs1_addr_i = rs1; id_rs2_addr_i = rs2;
      id_rs1_read_i = rd1; id_rs2_read_i = rd2;
      ex_rd_addr_i = exrd; ex_wreg_i = wr; ex_is_load_i = ld;
      ex_branch_taken_i = br; if_req_i = ifq; if_ack_i = ifa;
      mem_req_i = mq; mem_ack_i = ma;
      if (pat == P_RST) begin
         m_stall = 0;
         m_flush = 0;
      end
      e.tag  = tag;
      e.ctrl = pat_ctrl(pat);
      e.berr = berr;
      e.st   = 32'(m_stall);
      e.fl   = 32'(m_flush);
      sb_q.push_back(e);
      if (pat == P_MEM || pat == P_LU || pat == P_FS) m_stall++;
      if (pat == P_BR) m_flush++;
      @(negedge clk);
      e = sb_q.pop_front();
      chk(e.tag, "pc",     32'(pc_ctrl_o),     32'(e.ctrl[9:8]));
      chk(e.tag, "if_id",  32'(if_id_ctrl_o),  32'(e.ctrl[7:6]));
      chk(e.tag, "id_ex",  32'(id_ex_ctrl_o),  32'(e.ctrl[5:4]));
      chk(e.tag, "ex_mem", 32'(ex_mem_ctrl_o), 32'(e.ctrl[3:2]));
      chk(e.tag, "mem_wb", 32'(mem_wb_ctrl_o), 32'(e.ctrl[1:0]));
      chk(e.tag, "bus_err", 32'(bus_err_o),    32'(e.berr));
      chk(e.tag, "stall_cnt", stall_cnt_o,     e.st);
      chk(e.tag, "flush_cnt", flush_cnt_o,     e.fl);
   endtask

   initial begin
      //   tag        rst   rs1   rs2  r1   r2   exrd  wr   ld   br   ifq  ifa  mq   ma   pattern berr
      step("reset",   1'b0, 5'd0, 5'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,P_RST, 1'b0);
      step("idle0",   1'b1, 5'd0, 5'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,P_NORM,1'b0);
      step("lu_rs1",  1'b1, 5'd5, 5'd0,1'b1,1'b0,5'd5, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,P_LU,  1'b0);
      step("idle1",   1'b1, 5'd0, 5'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,P_NORM,1'b0);
      step("lu_rd0",  1'b1, 5'd0, 5'd0,1'b1,1'b1,5'd0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,P_NORM,1'b0);
      step("lu_rs2",  1'b1, 5'd3, 5'd7,1'b0,1'b1,5'd7, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,P_LU,  1'b0);
      step("rs2_nrd", 1'b1, 5'd3, 5'd7,1'b0,1'b0,5'd7, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,P_NORM,1'b0);
      step("no_load", 1'b1, 5'd7, 5'd0,1'b1,1'b0,5'd7, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,P_NORM,1'b0);
      step("fetch",   1'b1, 5'd0, 5'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,P_FS,  1'b0);
      step("fetch_ok",1'b1, 5'd0, 5'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,P_NORM,1'b0);
      step("br_all",  1'b1, 5'd9, 5'd0,1'b1,1'b0,5'd9, 1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,P_BR,  1'b0);
      step("idle2",   1'b1, 5'd0, 5'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,P_NORM,1'b0);
      step("mem_w0",  1'b1, 5'd0, 5'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,P_MEM, 1'b0);
      step("mem_w1",  1'b1, 5'd0, 5'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,P_MEM, 1'b0);
      step("mem_w2",  1'b1, 5'd0, 5'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,P_MEM, 1'b0);
      step("mem_ack", 1'b1, 5'd0, 5'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,P_NORM,1'b0);
      step("idle3",   1'b1, 5'd0, 5'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,P_NORM,1'b0);
      chk("idle3", "state", 32'(dut.state_q), 32'(RUN));
      step("br_mem0", 1'b1, 5'd0, 5'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,P_MEM, 1'b0);
      step("br_mem1", 1'b1, 5'd0, 5'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,P_MEM, 1'b0);
      step("to_w1",   1'b1, 5'd0, 5'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,P_MEM, 1'b0);
      step("to_w2",   1'b1, 5'd0, 5'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,P_MEM, 1'b0);
      step("to_hit",  1'b1, 5'd0, 5'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,P_NORM,1'b1);
      step("to_after",1'b1, 5'd0, 5'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,P_NORM,1'b0);
      step("rw_w0",   1'b1, 5'd0, 5'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,P_MEM, 1'b0);
      step("rw_w1",   1'b1, 5'd0, 5'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,P_MEM, 1'b0);
      step("rw_rst0", 1'b0, 5'd0, 5'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,P_RST, 1'b0);
      step("rw_rst1", 1'b0, 5'd0, 5'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,P_RST, 1'b0);
      step("rw_rel",  1'b1, 5'd0, 5'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,P_NORM,1'b0);
      step("rw_idle", 1'b1, 5'd0, 5'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,P_NORM,1'b0);
      chk("rw_idle", "state", 32'(dut.state_q), 32'(RUN));
      // A fresh timeout after reset shows the wait counter restarted from zero.
      step("rt_w0",   1'b1, 5'd0, 5'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,P_MEM, 1'b0);
      step("rt_w1",   1'b1, 5'd0, 5'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,P_MEM, 1'b0);
      step("rt_w2",   1'b1, 5'd0, 5'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,P_MEM, 1'b0);
      step("rt_w3",   1'b1, 5'd0, 5'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,P_MEM, 1'b0);
      step("rt_hit",  1'b1, 5'd0, 5'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,P_NORM,1'b1);
      step("rt_end",  1'b1, 5'd0, 5'd0,1'b0,1'b0,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,P_NORM,1'b0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
